multi_debounce: RTL
===================

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 Parameter CH, default 4: number of independent input channels, 1..16.
REQ-002 Parameter DLY, default 1048576 (2**20): stability window in clk cycles, at least 1.
REQ-003 Parameter DLY_W, default 21: width of the per-channel delay counter; DLY SHALL be less than 2**DLY_W.
REQ-004 Parameter CNT_W, default 8: width of the per-channel event counter.
REQ-005 Parameter SAT, default 0: event-counter mode; 0 = wrap with sticky overflow, 1 = saturate at all-ones.
REQ-006 clk  in  1  single clock; all state is updated on the rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 din  in  CH  raw, asynchronous, bouncing inputs, one bit per channel.
REQ-009 clr  in  1  synchronous clear of all event counters and overflow flags.
REQ-010 level  out  CH  debounced level per channel, registered.
REQ-011 rise  out  CH  one-cycle pulse on an accepted 0->1 transition, registered.
REQ-012 fall  out  CH  one-cycle pulse on an accepted 1->0 transition, registered.
REQ-013 cnt  out  CH*CNT_W  packed event counters; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-014 ovf  out  CH  sticky per-channel counter-wrap flag; always 0 when SAT=1.

Function
REQ-015 Each din bit SHALL pass through a 2-flop synchroniser; the second stage is called ds[i].
REQ-016 Each channel SHALL run an independent FSM with states S_LO, S_CHK_HI, S_HI, S_CHK_LO.
REQ-017 S_LO: ds=1 goes to S_CHK_HI with the delay counter set to 0; otherwise the FSM stays in S_LO.
REQ-018 S_CHK_HI:
  - ds=0: return to S_LO (bounce rejected; no pulse, no count).
  - ds=1 and delay counter = DLY-1: go to S_HI.
  - otherwise: increment the delay counter.
REQ-019 S_HI and S_CHK_LO SHALL mirror REQ-017/018 with the polarity inverted; S_CHK_LO returns to S_HI on ds=1.
REQ-020 The delay counter SHALL hold 0 in S_LO and S_HI; it never wraps.
REQ-021 level[i] SHALL be 1 exactly in states S_HI and S_CHK_LO.
REQ-022 rise[i] SHALL be 1 for exactly the one cycle in which level[i] first reads 1 (S_CHK_HI->S_HI); fall[i] likewise for S_CHK_LO->S_LO.
REQ-023 Latency: a din edge held stable SHALL appear on level exactly DLY+3 clk cycles later (2 sync + 1 entry + DLY count).
REQ-024 Any ds glitch shorter than DLY+1 cycles SHALL produce no change on level, rise, fall or cnt.
REQ-025 Event counting:
  - cnt[i] SHALL increment by 1 in the same update that asserts rise[i].
  - SAT=0: all-ones+1 wraps to 0 and sets ovf[i].
  - SAT=1: cnt[i] holds at all-ones.
REQ-026 clr=1 SHALL zero every cnt and ovf on the next edge.
REQ-027 If clr and an increment coincide on a channel, that channel's cnt SHALL become 1 and its ovf 0.
REQ-028 clr SHALL NOT affect the FSMs, level, rise or fall.
REQ-029 Channels SHALL be fully independent; simultaneous events on several channels are each handled per REQ-016..027.

Reset
REQ-030 rst=1 SHALL asynchronously force all of the following to 0: synchronisers, delay counters, level, rise, fall, cnt, ovf; all FSMs go to S_LO.
REQ-031 rst asserted mid-window SHALL discard the pending transition; after release, din=1 is re-qualified from the beginning (full DLY+3 latency).

Verification (DLY=4, CH=4, CNT_W=3)
REQ-032 Step: din[0] 0->1 held -> level[0]=1 and rise[0]=1 on cycle 7 after the edge; cnt[0]=1; other channels unchanged.
REQ-033 Bounce: din[1] high 4 cycles, low 1, high held -> no pulse during the bounce; level[1] rises 7 cycles after the final edge; cnt[1]=1.
REQ-034 Wrap: 8 clean pulses on ch2 with SAT=0 -> cnt[2]=0, ovf[2]=1; same with SAT=1 -> cnt[2]=7, ovf[2]=0.
REQ-035 clr coinciding with rise[3] -> cnt[3]=1, ovf[3]=0; level[3]=1 unaffected.
REQ-036 rst pulse at cycle 4 of a qualification window -> all outputs 0 immediately; after release with din held 1, level rises 7 cycles after release.
REQ-037 All 4 channels stepped on the same cycle -> rise=4'b1111 for one cycle; each cnt=1.

Source files
------------

// File: rtl/multi_debounce.sv
// rtl/multi_debounce.sv - multi-channel input debouncer with edge pulses and event counters
//
// Purpose: each din bit is synchronised, then qualified by a per-channel FSM
// that only accepts a new level once it has been stable for DLY+1 samples.
// Accepted rising edges are counted per channel (wrap+sticky ovf, or saturate).
//
// Ports:
//   clk    in   1         single clock, rising edge
//   rst    in   1         asynchronous active-high reset
//   din    in   CH        raw bouncing inputs
//   clr    in   1         synchronous clear of cnt/ovf (FSMs untouched)
//   level  out  CH        debounced level
//   rise   out  CH        one-cycle pulse on accepted 0->1
//   fall   out  CH        one-cycle pulse on accepted 1->0
//   cnt    out  CH*CNT_W  event counters, channel i at [i*CNT_W +: CNT_W]
//   ovf    out  CH        sticky counter-wrap flags (0 when SAT=1)
module multi_debounce #(
  parameter int CH    = 4,
  parameter int DLY   = 1048576,
  parameter int DLY_W = 21,
  parameter int CNT_W = 8,
  parameter int SAT   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       din,
  input  logic                clr,
  output logic [CH-1:0]       level,
  output logic [CH-1:0]       rise,
  output logic [CH-1:0]       fall,
  output logic [CH*CNT_W-1:0] cnt,
  output logic [CH-1:0]       ovf
);

  typedef enum logic [1:0] {S_LO, S_CHK_HI, S_HI, S_CHK_LO} state_t;

  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CH-1:0] sync1_q;
  logic [CH-1:0] sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             ds;

    assign ds = sync2_q[i];

    always_comb begin
      state_d = state_q;
      // The delay counter is only meaningful in the two check states; any
      // path that does not explicitly advance it falls back to zero.
      dly_d   = '0;
      case (state_q)
        S_LO:     if (ds) state_d = S_CHK_HI;
        S_CHK_HI: begin
          if (!ds)                  state_d = S_LO;
          else if (dly_q == DLY_LAST) state_d = S_HI;
          else                      dly_d = dly_q + 1'b1;
        end
        S_HI:     if (!ds) state_d = S_CHK_LO;
        S_CHK_LO: begin
          if (ds)                   state_d = S_HI;
          else if (dly_q == DLY_LAST) state_d = S_LO;
          else                      dly_d = dly_q + 1'b1;
        end
        default:  state_d = S_LO;
      endcase

      // Outputs are registered from the next state so they line up with it.
      level_d = (state_d == S_HI) || (state_d == S_CHK_LO);
      rise_d  = (state_q == S_CHK_HI) && (state_d == S_HI);
      fall_d  = (state_q == S_CHK_LO) && (state_d == S_LO);

      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (rise_d) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end else if (SAT == 0) begin
          cnt_d = '0;
          ovf_d = 1'b1;
        end
      end
      // clr wins over the old value but still counts a coincident rise.
      if (clr) begin
        cnt_d = rise_d ? CNT_ONE : '0;
        ovf_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_LO;
        dly_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        dly_q   <= dly_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        cnt_q   <= cnt_d;
        ovf_q   <= ovf_d;
      end
    end

    assign level[i]                 = level_q;
    assign rise[i]                  = rise_q;
    assign fall[i]                  = fall_q;
    assign cnt[i*CNT_W +: CNT_W]    = cnt_q;
    assign ovf[i]                   = ovf_q;
  end

endmodule
